// File: rtl/obi_apb_arb_pkg.sv
// Shared types and constants for the OBI-to-APB arbiter slice.
// The optional watchdog is enabled with the macro OBI_APB_ARB_TIMEOUT_EN.
package obi_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hBADC_0FFE;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_rr_pick.sv
// Combinational round-robin picker: the first requester after i_last (cyclically) wins.
module obi_rr_pick
    import obi_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int w_dist;
    int w_best;

    // Pick the requesting index with the smallest cyclic distance past i_last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + 2 * NUM_REQ - int'(i_last) - 1) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end else begin
                w_best  = w_best;
            end
        end
    end

endmodule

// File: rtl/obi_apb_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate (APB bridge) among NUM_REQ managers.
// Optional response watchdog: define OBI_APB_ARB_TIMEOUT_EN.
module obi_apb_arbiter
    import obi_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    input  logic [NUM_REQ*32-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]      we_i,
    input  logic [NUM_REQ*4-1:0]    be_i,
    input  logic [NUM_REQ*32-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]      rvalid_o,
    output logic [31:0]             rdata_o,
    output logic                    err_o,
    output logic                    m_req_o,
    input  logic                    m_gnt_i,
    output logic [31:0]             m_addr_o,
    output logic                    m_we_o,
    output logic [3:0]              m_be_o,
    output logic [31:0]             m_wdata_o,
    input  logic                    m_rvalid_i,
    input  logic [31:0]             m_rdata_i,
    input  logic                    m_err_i
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_e             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr;
    logic               r_err;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_we;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_accept;
    logic               w_resp;
    logic               w_timeout;

    obi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req_i),
        .i_last  (r_rr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Gating with rst_ni keeps gnt_o low while reset is held.
    assign w_accept = (r_state == IDLE) && w_pick_valid && rst_ni;
    assign w_resp   = ((r_state == FWD) && m_gnt_i && m_rvalid_i) ||
                      ((r_state == RESP) && m_rvalid_i);

`ifdef OBI_APB_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_timeout = (r_state != IDLE) && !w_resp &&
                       (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on acceptance, counts every busy cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= 16'd0;
        end else if (w_accept) begin
            r_cnt <= 16'd0;
        end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end
`else
    // Constant false; TIMEOUT_CYCLES only matters when the watchdog is built in.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Transaction FSM with request capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rr    <= IDX_W'(NUM_REQ - 1);
            r_err   <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= FWD;
                        r_owner <= w_pick_idx;
                        r_rr    <= w_pick_idx;
                        r_addr  <= addr_i[32*w_pick_idx +: 32];
                        r_wdata <= wdata_i[32*w_pick_idx +: 32];
                        r_be    <= be_i[4*w_pick_idx +: 4];
                        r_we    <= we_i[w_pick_idx];
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FWD: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                    end else if (m_gnt_i) begin
                        r_err   <= m_err_i;
                        r_state <= m_rvalid_i ? IDLE : RESP;
                    end else begin
                        r_state <= FWD;
                    end
                end
                RESP: begin
                    if (w_resp || w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant and response routing; all response outputs are zero outside a response cycle.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        rdata_o  = 32'h0;
        err_o    = 1'b0;
        if (w_accept) begin
            gnt_o[w_pick_idx] = 1'b1;
        end else begin
            gnt_o = '0;
        end
        if (w_timeout) begin
            rvalid_o[r_owner] = 1'b1;
            rdata_o           = TIMEOUT_RDATA;
            err_o             = 1'b1;
        end else if (w_resp) begin
            rvalid_o[r_owner] = 1'b1;
            rdata_o           = m_rdata_i;
            err_o             = (r_state == RESP) ? (r_err | m_err_i) : m_err_i;
        end else begin
            rvalid_o = '0;
        end
    end

    assign m_req_o   = (r_state == FWD) && !w_timeout;
    assign m_addr_o  = r_addr;
    assign m_we_o    = r_we;
    assign m_be_o    = r_be;
    assign m_wdata_o = r_wdata;

endmodule

// File: tb/tb_obi_apb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// against a transaction-level model of the arbiter.
module tb_obi_apb_arbiter;

    localparam int NR = 2;
`ifdef OBI_APB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_i, gnt_o, we_i, rvalid_o;
    logic [NR*32-1:0]  addr_i, wdata_i;
    logic [NR*4-1:0]   be_i;
    logic [31:0]       rdata_o, m_addr_o, m_wdata_o, m_rdata_i;
    logic              err_o, m_req_o, m_gnt_i, m_we_o, m_rvalid_i, m_err_i;
    logic [3:0]        m_be_o;

    always #5 clk_i = ~clk_i;

    obi_apb_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model: busy phase 0=free, 1=waiting for bridge grant, 2=waiting for data.
    int          phase, last, owner, ws_left, rd_left;
    logic        merr, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int from);
        for (int k = 1; k <= NR; k++) begin
            if (r[(from + k) % NR]) return (from + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        phase = 0; last = NR - 1; owner = 0; merr = 1'b0;
        c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0; c_we = 1'b0;
    endtask

    task automatic set_bridge(input logic g, input logic rv, input logic [31:0] d, input logic e);
        m_gnt_i = g; m_rvalid_i = rv; m_rdata_i = d; m_err_i = e;
    endtask

    // Compare every DUT output against the model for the inputs currently applied.
    task automatic check();
        logic [NR-1:0] eg, erv;
        logic [31:0]   ed;
        logic          ee;
        int            w;
        #1;
        eg = '0; erv = '0; ed = 32'h0; ee = 1'b0;
        w = pick(req_i, last);
        if (phase == 0 && w >= 0) eg[w] = 1'b1;
        if ((phase == 1 && m_gnt_i && m_rvalid_i) || (phase == 2 && m_rvalid_i)) begin
            erv[owner] = 1'b1;
            ed = m_rdata_i;
            ee = m_err_i | ((phase == 2) ? merr : 1'b0);
        end
        chk("gnt_o", 32'(gnt_o), 32'(eg));
        chk("rvalid_o", 32'(rvalid_o), 32'(erv));
        chk("rdata_o", rdata_o, ed);
        chk("err_o", 32'(err_o), 32'(ee));
        chk("m_req_o", 32'(m_req_o), 32'(phase == 1));
        chk("m_addr_o", m_addr_o, c_addr);
        chk("m_wdata_o", m_wdata_o, c_wdata);
        chk("m_be_o", 32'(m_be_o), 32'(c_be));
        chk("m_we_o", 32'(m_we_o), 32'(c_we));
    endtask

    // Move the model across the coming clock edge, then wait for the next drive point.
    task automatic advance();
        int w;
        w = pick(req_i, last);
        if (phase == 0) begin
            if (w >= 0) begin
                c_addr = addr_i[w*32 +: 32]; c_wdata = wdata_i[w*32 +: 32];
                c_be = be_i[w*4 +: 4]; c_we = we_i[w];
                owner = w; last = w; phase = 1;
            end
        end else if (phase == 1) begin
            if (m_gnt_i) begin
                merr = m_err_i;
                phase = m_rvalid_i ? 0 : 2;
            end
        end else if (m_rvalid_i) begin
            phase = 0;
        end
        @(negedge clk_i);
    endtask

    task automatic step();
        check();
        advance();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_m_req", 32'(m_req_o), 32'h0);
        chk("rst_m_addr", m_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    // Randomized request and bridge behaviour; bridge latency stays below the watchdog limit.
    task automatic drive_random();
        req_i = NR'($urandom);
        we_i  = NR'($urandom);
        be_i  = (NR*4)'($urandom);
        for (int i = 0; i < NR; i++) begin
            addr_i[i*32 +: 32]  = $urandom;
            wdata_i[i*32 +: 32] = $urandom;
        end
        set_bridge(1'b0, 1'b0, $urandom, ($urandom_range(0, 3) == 0));
        if (phase == 0) begin
            m_gnt_i    = ($urandom_range(0, 7) == 0);
            m_rvalid_i = ($urandom_range(0, 7) == 0);
            ws_left    = $urandom_range(0, 3);
            rd_left    = $urandom_range(0, 2);
        end else if (phase == 1) begin
            if (ws_left == 0) begin
                m_gnt_i = 1'b1;
                m_rvalid_i = (rd_left == 0);
            end else begin
                ws_left--;
            end
        end else begin
            if (rd_left <= 1) m_rvalid_i = 1'b1;
            else rd_left--;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [NR-1:0] exp_order [4];

    initial begin
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Single read, zero wait states.
        req_i = 2'b01; addr_i[31:0] = 32'h0000_1004; be_i = 8'h0F;
        check(); chk("sr_gnt", 32'(gnt_o), 32'h1); advance();
        req_i = 2'b00;
        check(); chk("sr_mreq1", 32'(m_req_o), 32'h1); chk("sr_maddr", m_addr_o, 32'h0000_1004); advance();
        set_bridge(1'b1, 1'b0, 32'h0, 1'b0);
        check(); chk("sr_mreq2", 32'(m_req_o), 32'h1); advance();
        set_bridge(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        check(); chk("sr_rvalid", 32'(rvalid_o), 32'h1); chk("sr_rdata", rdata_o, 32'h1234_5678);
        chk("sr_err", 32'(err_o), 32'h0); advance();
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);

        // Contention: both requesting for four transfers.
        do_reset();
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            set_bridge(1'b0, 1'b0, 32'h0, 1'b0);
            check(); chk("ct_gnt", 32'(gnt_o), 32'(exp_order[t])); advance();
            check(); advance();
            set_bridge(1'b1, 1'b0, 32'h0, 1'b0);
            check(); advance();
            set_bridge(1'b0, 1'b1, 32'hC0DE_0000 + t, 1'b0);
            check(); chk("ct_rvalid", 32'(rvalid_o), 32'(exp_order[t])); advance();
        end
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);

        // Slave error on a write from requester 1.
        req_i = 2'b10; we_i = 2'b10; addr_i[63:32] = 32'h0000_2000;
        check(); chk("se_gnt", 32'(gnt_o), 32'h2); advance();
        req_i = 2'b00;
        set_bridge(1'b1, 1'b0, 32'h0, 1'b1);
        check(); chk("se_mwe", 32'(m_we_o), 32'h1); advance();
        set_bridge(1'b0, 1'b1, 32'h0, 1'b0);
        check(); chk("se_rvalid", 32'(rvalid_o), 32'h2); chk("se_err", 32'(err_o), 32'h1); advance();
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);

        // Three wait states; the requester changes its address after the grant.
        req_i = 2'b01; we_i = 2'b00; addr_i[31:0] = 32'h0000_00A0;
        check(); chk("ws_gnt", 32'(gnt_o), 32'h1); advance();
        req_i = 2'b00; addr_i[31:0] = 32'hFFFF_0000;
        for (int k = 0; k < 4; k++) begin
            m_gnt_i = (k == 3);
            check(); chk("ws_mreq", 32'(m_req_o), 32'h1); chk("ws_maddr", m_addr_o, 32'h0000_00A0); advance();
        end
        set_bridge(1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
        check(); chk("ws_rvalid", 32'(rvalid_o), 32'h1); advance();
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while waiting for the response.
        req_i = 2'b10;
        step();
        req_i = 2'b00; m_gnt_i = 1'b1;
        step();
        rst_ni = 1'b0; req_i = 2'b11; set_bridge(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("rr_rvalid", 32'(rvalid_o), 32'h0); chk("rr_gnt", 32'(gnt_o), 32'h0);
        chk("rr_rdata", rdata_o, 32'h0); chk("rr_maddr", m_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1; model_reset();
        check(); chk("rr_first_gnt", 32'(gnt_o), 32'h1); chk("rr_stray", 32'(rvalid_o), 32'h0); advance();
        do_reset();

`ifdef OBI_APB_ARB_TIMEOUT_EN
        // Watchdog: the bridge never grants.
        req_i = 2'b01; addr_i[31:0] = 32'h0000_3000;
        step();
        req_i = 2'b00;
        for (int k = 1; k <= TO; k++) begin
            #1;
            if (k < TO) begin
                chk("to_mreq", 32'(m_req_o), 32'h1); chk("to_early", 32'(rvalid_o), 32'h0);
            end else begin
                chk("to_rvalid", 32'(rvalid_o), 32'h1); chk("to_err", 32'(err_o), 32'h1);
                chk("to_rdata", rdata_o, 32'hBADC_0FFE); chk("to_mreq_drop", 32'(m_req_o), 32'h0);
            end
            @(negedge clk_i);
        end
        phase = 0;
        set_bridge(1'b1, 1'b1, 32'h7777_7777, 1'b0);
        check(); chk("to_late", 32'(rvalid_o), 32'h0); advance();
        set_bridge(1'b0, 1'b0, 32'h0, 1'b0);
`endif

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_apb_arbiter.md
# obi_apb_arbiter

Shares one OBI subordinate port (the OBI-to-APB bridge in front of the peripheral bus) between NUM_REQ OBI managers. Fair round-robin arbitration, one outstanding transaction, request capture so the downstream bus sees stable fields, and response and error routing back to the owning requester. Sits between the core-side crossbar and the APB bridge.

## Interface
- NUM_REQ, default 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, default 255: watchdog limit in cycles, 1..65535. Used only with the timeout feature compiled in.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset. One clock; reset is asynchronous and active-low.
- req_i, input, NUM_REQ: per-requester OBI req.
- gnt_o, output, NUM_REQ: per-requester OBI gnt.
- addr_i, input, NUM_REQ*32: packed; requester i occupies bits [32i+31:32i].
- we_i, input, NUM_REQ: write enable.
- be_i, input, NUM_REQ*4: byte enables.
- wdata_i, input, NUM_REQ*32: write data.
- rvalid_o, output, NUM_REQ: per-requester response valid.
- rdata_o, output, 32: shared read data, qualified by rvalid_o[i].
- err_o, output, 1: shared error flag, qualified by rvalid_o[i].
- m_req_o, output, 1: request to the bridge.
- m_gnt_i, input, 1: grant from the bridge.
- m_addr_o, output, 32: address to the bridge.
- m_we_o, output, 1: write enable to the bridge.
- m_be_o, output, 4: byte enables to the bridge.
- m_wdata_o, output, 32: write data to the bridge.
- m_rvalid_i, input, 1: response valid from the bridge.
- m_rdata_i, input, 32: read data from the bridge.
- m_err_i, input, 1: error from the bridge. Valid in the m_gnt_i cycle.

## Operation
- The FSM has three states: IDLE, FWD and RESP.
- **IDLE**
  - If any req_i is high, the round-robin pick selects the winner w and gnt_o[w]=1 in the same cycle (combinational).
  - On that edge, capture addr/we/be/wdata of w into the m_* registers, set owner_q=w and rr_q=w, then go to FWD.
  - No request: stay in IDLE.
- **Round-robin pick**: search indices rr_q+1, rr_q+2, … modulo NUM_REQ; the first one with req_i high wins.
- **FWD**
  - m_req_o=1 with the captured fields.
  - On m_gnt_i: register err_q=m_err_i and go to RESP.
  - If m_rvalid_i is high in the same cycle as m_gnt_i, deliver the response immediately (see RESP) and go to IDLE.
- **RESP**
  - m_req_o=0.
  - On m_rvalid_i: rvalid_o[owner_q]=1, rdata_o=m_rdata_i, err_o=err_q|m_err_i, then go to IDLE.
- gnt_o is never asserted outside IDLE, so each requester has at most one transaction accepted.
- In IDLE, m_rvalid_i and m_gnt_i are ignored; stray responses never reach a requester.
- **Outputs outside a response cycle**: rdata_o=0, err_o=0, rvalid_o=0.
- **Index width**: owner_q and rr_q are IdxW=max(1,$clog2(NUM_REQ)) bits wide.

## Timing
- **Reset values**
  - State: IDLE.
  - rr_q=NUM_REQ-1, so requester 0 wins first.
  - owner_q=0, err_q=0.
  - m_addr_o, m_wdata_o and m_be_o = 0; m_we_o=0; m_req_o=0.
  - gnt_o, rvalid_o, rdata_o and err_o = 0.
- **Zero-wait-state APB**
  - Cycle N: gnt_o.
  - N+1: m_req_o, bridge in SETUP.
  - N+2: m_gnt_i (ACCESS with pready).
  - N+3: m_rvalid_i and rvalid_o.
  - N+4: IDLE, next arbitration.
  - Throughput: one transfer per 4 cycles.
- APB wait states extend FWD one cycle per wait state.
- m_* fields stay constant from the FWD entry edge until the return to IDLE.
- Reset asserted mid-transfer returns to the reset values immediately. Any in-flight response is lost; the owner never sees rvalid.
- If requesters deassert req_i after gnt_o, there is no effect: the fields are already captured.

## Configuration
- **OBI_APB_ARB_TIMEOUT_EN defined**
  - A 16-bit counter clears on entering FWD and increments each cycle in FWD or RESP.
  - When the count reaches TIMEOUT_CYCLES-1 without a response: rvalid_o[owner_q]=1, err_o=1, rdata_o=32'hBADC0FFE, m_req_o drops, and the FSM goes to IDLE.
  - A late m_gnt_i or m_rvalid_i arriving afterwards is discarded by the IDLE rule.
- **Macro undefined**: no counter; the FSM waits indefinitely; TIMEOUT_CYCLES is unused.

## Structure
- Package obi_apb_arb_pkg holds:
  - state_e (IDLE, FWD, RESP, 2-bit);
  - the TIMEOUT_RDATA constant 32'hBADC0FFE;
  - the function computing IdxW.
- Sub-module obi_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: valid, winner index.
  - Instantiated once.

## Test plan
- **Single read, zero wait**: req_i=2'b01, addr 0x0000_1004; bridge model returns rdata 0x1234_5678 → gnt_o[0] at N, m_req_o N+1..N+2, rvalid_o[0] with rdata_o=0x1234_5678 at N+3, err_o=0.
- **Contention**: req_i=2'b11 held for 4 transfers → winners in order 0,1,0,1; each request is granted exactly once per turn.
- **Slave error**: m_err_i=1 in the m_gnt_i cycle of a write to requester 1 → rvalid_o[1] with err_o=1 one cycle later.
- **Wait states**: 3-cycle pready delay → FWD lasts 4 cycles; m_addr_o stays stable even though addr_i[0] changes after gnt_o.
- **Reset in RESP**: assert rst_ni low → all outputs at reset values; after release, requester 0 is granted first and no rvalid_o occurs for the aborted transfer.
- **Timeout (macro on, TIMEOUT_CYCLES=8)**: m_gnt_i never asserted → rvalid_o[0] with err_o=1 and rdata_o=0xBADC0FFE 8 cycles after FWD entry; a later m_rvalid_i is ignored.
